// File: rtl/bcd_countdown_timer.sv
// Cascaded BCD countdown timer: parallel load, start/pause control, per-digit borrows, done pulse.
// Optional: define BCD_COUNTDOWN_AUTO_RELOAD_EN to reload the last valid load value on expiry.
module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   q,
  output logic [DIGITS-1:1]     borrow,
  output logic                  busy,
  output logic                  done,
  output logic                  load_err
);
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    q_reg, q_next, q_dec, reload_val;
  logic            done_reg, done_next, err_reg, err_next;
  logic [DIGITS:0] zero_prefix;
  logic [DIGITS-1:0] digit_bad;
  logic            te, load_acc, load_ok, q_is_zero, q_is_one, expire, reload_hit;

  // zero_prefix[i]: digits 0..i-1 are all zero, i.e. digit i takes a borrow on te
  assign zero_prefix[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      assign d                  = q_reg[4*gi +: 4];
      assign zero_prefix[gi+1]  = zero_prefix[gi] && (d == 4'd0);
      assign q_dec[4*gi +: 4]   = zero_prefix[gi] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
      assign digit_bad[gi]      = load_value[4*gi +: 4] > 4'd9;
    end
    for (gi = 1; gi < DIGITS; gi++) begin : g_borrow
      assign borrow[gi] = te && zero_prefix[gi];
    end
  endgenerate

  assign te        = tick && (state_reg == RUN) && !pause;
  assign load_acc  = load_valid && (state_reg == IDLE);
  assign load_ok   = ~|digit_bad;
  assign q_is_zero = zero_prefix[DIGITS];
  assign q_is_one  = (q_reg == ONE);
  assign expire    = te && q_is_one;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  logic [W-1:0] reload_reg;
  always_ff @(posedge clk) begin
    if (reset)
      reload_reg <= '0;
    else if (load_acc && load_ok)
      reload_reg <= load_value;
  end
  assign reload_val = reload_reg;
`else
  assign reload_val = '0;
`endif
  assign reload_hit = (reload_val != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic; a same-cycle load request always suppresses start
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!load_valid && start && !q_is_zero) state_next = RUN;
      RUN: begin
        if (pause)                      state_next = HOLD;
        else if (expire && !reload_hit) state_next = IDLE;
      end
      HOLD:    if (!pause) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    load_ready = (state_reg == IDLE);
    busy       = (state_reg != IDLE);
  end

  // Count and pulse datapath
  always_comb begin
    q_next    = q_reg;
    done_next = 1'b0;
    err_next  = 1'b0;
    if (load_acc) begin
      if (load_ok) q_next   = load_value;
      else         err_next = 1'b1;
    end else if ((state_reg == IDLE) && start && q_is_zero) begin
      done_next = 1'b1;
    end else if (expire) begin
      q_next    = reload_val;
      done_next = 1'b1;
    end else if (te) begin
      q_next = q_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg    <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      q_reg    <= q_next;
      done_reg <= done_next;
      err_reg  <= err_next;
    end
  end

  assign q        = q_reg;
  assign done     = done_reg;
  assign load_err = err_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed vector table, pause/reload sequences,
// and randomized traffic compared against an integer-count reference model.
module tb_bcd_countdown_timer;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset, load_valid, start, pause, tick;
  logic [15:0] load_value;
  logic        load_ready, busy, done, load_err;
  logic [15:0] q;
  logic [DIGITS-1:1] borrow;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .start(start), .pause(pause), .tick(tick),
    .q(q), .borrow(borrow), .busy(busy), .done(done), .load_err(load_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state 0=idle 1=run 2=hold, count kept as a plain integer
  int       m_state = 0, m_cnt = 0, m_reload = 0;
  bit       m_done = 0, m_err = 0;
  logic [2:0] last_borrow;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int x;
    x = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    int s, w;
    s = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      s = s + int'(v[4*i +: 4]) * w;
      w = w * 10;
    end
    return s;
  endfunction

  task automatic model_step(input logic r, lv, input logic [15:0] v, input logic s, p, t);
    bit te;
    te = t && (m_state == 1) && !p;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_reload = 0;
    end else if (m_state == 0) begin
      if (lv) begin
        if (bcd_ok(v)) begin
          m_cnt = from_bcd(v);
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
          m_reload = m_cnt;
`endif
        end else m_err = 1'b1;
      end else if (s) begin
        if (m_cnt == 0) m_done = 1'b1;
        else            m_state = 1;
      end
    end else if (m_state == 1) begin
      if (p) m_state = 2;
      else if (te) begin
        if (m_cnt == 1) begin
          m_done = 1'b1;
          if (m_reload != 0) m_cnt = m_reload;
          else begin m_cnt = 0; m_state = 0; end
        end else m_cnt = m_cnt - 1;
      end
    end else if (!p) m_state = 1;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, update model, check registers
  task automatic cycle(input logic r, lv, input logic [15:0] v, input logic s, p, t);
    bit te;
    logic [2:0] eb;
    int w;
    reset = r; load_valid = lv; load_value = v; start = s; pause = p; tick = t;
    #1;
    te = t && (m_state == 1) && !p;
    w = 1;
    for (int i = 1; i < 4; i++) begin
      w = w * 10;
      eb[i-1] = te && (m_cnt % w == 0);
    end
    last_borrow = borrow;
    check("borrow", 32'(borrow), 32'(eb));
    check("load_ready_pre", 32'(load_ready), 32'(m_state == 0));
    @(posedge clk);
    model_step(r, lv, v, s, p, t);
    #1;
    check("q", 32'(q), 32'(to_bcd(m_cnt)));
    check("done", 32'(done), 32'(m_done));
    check("load_err", 32'(load_err), 32'(m_err));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("load_ready", 32'(load_ready), 32'(m_state == 0));
    @(negedge clk);
  endtask

  typedef struct {
    logic r, lv;
    logic [15:0] v;
    logic s, p, t;
    logic [15:0] eq;
    logic ed, ee, eb;
    logic [2:0] ebr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    @(negedge clk);

    //           r  lv value       s  p  t  exp_q       d  e  b  borrow
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 1, 16'h0003, 0, 0, 0, 16'h0003, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h0003, 0, 0, 1, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0002, 0, 0, 1, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0001, 0, 0, 1, 3'b000});
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0003, 1, 0, 1, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0002, 0, 0, 1, 3'b000});
`else
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 0, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0, 3'b000});
`endif
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h1000, 0, 0, 1, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0999, 0, 0, 1, 3'b111});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 1, 16'h0A12, 0, 0, 0, 16'h0000, 0, 1, 0, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 1, 16'h0912, 0, 0, 0, 16'h0912, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 1, 16'h0003, 1, 0, 0, 16'h0003, 0, 0, 0, 3'b000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 1, 16'h0040, 0, 0, 0, 16'h0040, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h0040, 0, 0, 1, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0039, 0, 0, 1, 3'b001});
    tbl.push_back('{0, 1, 16'h0A00, 0, 0, 1, 16'h0038, 0, 0, 1, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0037, 0, 0, 1, 3'b000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0, 3'b000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 3'b000});

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].lv, tbl[i].v, tbl[i].s, tbl[i].p, tbl[i].t);
      check("vec_q", 32'(q), 32'(tbl[i].eq));
      check("vec_done", 32'(done), 32'(tbl[i].ed));
      check("vec_err", 32'(load_err), 32'(tbl[i].ee));
      check("vec_busy", 32'(busy), 32'(tbl[i].eb));
      check("vec_borrow", 32'(last_borrow), 32'(tbl[i].ebr));
      $display("vec %0d: r=%0b lv=%0b v=%h s=%0b p=%0b t=%0b -> q=%h done=%0b err=%0b busy=%0b",
               i, tbl[i].r, tbl[i].lv, tbl[i].v, tbl[i].s, tbl[i].p, tbl[i].t, q, done, load_err, busy);
    end

    // Pause: hold at 0048 while pause is high, resume after it falls
    cycle(1, 0, 16'h0000, 0, 0, 0);
    cycle(0, 1, 16'h0050, 0, 0, 0);
    cycle(0, 0, 16'h0000, 1, 0, 0);
    cycle(0, 0, 16'h0000, 0, 0, 1);
    cycle(0, 0, 16'h0000, 0, 0, 1);
    check("pause_pre", 32'(q), 32'h0048);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 16'h0000, 0, 1, 1);
      check("pause_hold_q", 32'(q), 32'h0048);
      check("pause_busy", 32'(busy), 32'h1);
    end
    cycle(0, 0, 16'h0000, 0, 0, 0);
    check("pause_release_q", 32'(q), 32'h0048);
    cycle(0, 0, 16'h0000, 0, 0, 1);
    check("pause_resume_q", 32'(q), 32'h0047);
    $display("pause seq: q=%h busy=%0b", q, busy);

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    cycle(1, 0, 16'h0000, 0, 0, 0);
    cycle(0, 1, 16'h0002, 0, 0, 0);
    cycle(0, 0, 16'h0000, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 16'h0000, 0, 0, 1);
      check("reload_q", 32'(q), (i % 2 == 0) ? 32'h0001 : 32'h0002);
      check("reload_done", 32'(done), 32'(i % 2 == 1));
      check("reload_busy", 32'(busy), 32'h1);
      $display("reload seq %0d: q=%h done=%0b", i, q, done);
    end
`endif

    // Randomized traffic against the model
    cycle(1, 0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, lv, s, p, t;
      logic [15:0] v;
      r  = ($urandom_range(0, 199) == 0);
      lv = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : to_bcd(int'($urandom_range(0, 40)));
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 5) == 0);
      t  = ($urandom_range(0, 3) != 0);
      cycle(r, lv, v, s, p, t);
    end
    $display("random phase: %0d cycles", 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Cascaded BCD down-counter (countdown timer) with parallel load, start/pause control and terminal-count pulse.
- Complements the free-running BCD up-counter used for time/event display.
- Consumes a per-cycle tick enable; exposes per-digit borrow enables so downstream logic can track which digits change.

Parameters:
DIGITS, 4, number of BCD digits; q width is 4*DIGITS.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
load_valid  in  1  load request
load_ready  out  1  high when a load can be accepted (state IDLE)
load_value  in  4*DIGITS  BCD value to load, digit 0 in bits [3:0]
start  in  1  single-cycle start request
pause  in  1  level; while high, ticks are ignored in RUN
tick  in  1  count enable; one decrement per cycle when effective
q  out  4*DIGITS  current BCD count, registered
borrow  out  DIGITS-1  borrow[i] high when digit i decrements this cycle (i = 1..DIGITS-1), combinational
busy  out  1  high in RUN or HOLD
done  out  1  one-cycle pulse on expiry
load_err  out  1  one-cycle pulse when a rejected load contains a digit > 9

Behaviour:
- Reset:
  - State IDLE; q = 0; done = 0; load_err = 0.
  - load_ready = 1; busy = 0.
  - Reset overrides all other inputs in the same cycle.
- States:
  - IDLE: load_ready = 1.
  - RUN
  - HOLD: paused.
- Load (IDLE only):
  - Accepted on clk edge with load_valid && load_ready.
  - If every digit of load_value is <= 9: q <= load_value next cycle.
  - Otherwise q is unchanged and load_err pulses high for the next cycle.
  - load_valid outside IDLE is ignored; no error is flagged.
- Start:
  - In IDLE with start and no accepted load in the same cycle: q != 0 -> RUN.
  - q == 0 -> done pulses next cycle and state stays IDLE.
  - Load and start in the same cycle: load wins, start is dropped.
  - start in RUN or HOLD is ignored.
- Pause:
  - RUN with pause -> HOLD.
  - HOLD with !pause -> RUN.
  - Ticks are not counted while pause is high, including the cycle pause rises.
- Effective tick: te = tick && state == RUN && !pause.
- Decrement:
  - Digit 0 decrements on te.
  - Digit i (i >= 1) decrements on te && digits 0..i-1 all zero.
  - A digit at 0 that decrements wraps to 9; other digits subtract 1.
- borrow[i] = te && digits 0..i-1 all zero. It is valid in the cycle before the q update.
- Expiry:
  - On te with q == 1 (only digit 0 nonzero and equal to 1): q <= 0, state -> IDLE.
  - done pulses high for exactly the cycle in which q first reads 0.
- The count never underflows: RUN with q == 0 cannot persist.
- Reset during RUN/HOLD: immediate return to the reset values; no done pulse.
- done and load_err are registered and never high for more than one consecutive cycle.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - An internal reload register captures every accepted valid load; reset clears it to 0.
  - On expiry, q <= reload register instead of 0, done pulses, and state stays RUN.
  - If the reload register is 0, expiry behaves as in the undefined case.
- Undefined:
  - No reload register exists; expiry always goes to q = 0 and IDLE.

Test Plan:
- Reset then load 0x0003, start, tick every cycle -> q steps 0003, 0002, 0001, 0000; done high exactly with q = 0000; state returns to IDLE, load_ready = 1.
- Load 0x1000, start, single tick -> borrow[1], borrow[2], borrow[3] all high that cycle; q = 0999.
- Load 0x0A12 -> q unchanged, load_err one-cycle pulse. Then load 0x0912 -> q = 0912, no error.
- Load 0x0050, start, tick continuously, pause high for 5 cycles after 2 decrements -> q holds 0048 during pause and busy stays 1; resumes to 0047 on the first tick after pause falls.
- Start with q = 0000 -> done pulse next cycle, no RUN. Reset asserted mid-RUN at q = 0037 -> q = 0000, IDLE, no done pulse.
- With BCD_COUNTDOWN_AUTO_RELOAD_EN: load 0x0002, start, tick -> q sequence 0002, 0001, 0002, 0001 ...; done pulses each expiry; busy stays 1.
